rbs_serial_4bits: RTL and testbench
===================================

RBS_SERIAL_4BITS -- requirements
Module: rbs_serial_4bits

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port enable  input  1  global advance qualifier; low stalls computation.
REQ-005 SHALL have port start  input  1  request to begin a subtraction.
REQ-006 SHALL have port A  input  WIDTH  minuend.
REQ-007 SHALL have port B  input  WIDTH  subtrahend.
REQ-008 SHALL have port Bin  input  1  borrow-in.
REQ-009 SHALL have port Q  output  WIDTH+1  result {Bout, D}, where D = A-B-Bin mod 2^WIDTH and Bout is the final borrow.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion strobe.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL accept a request only in IDLE with start=1 and enable=1; on acceptance, latch A, B and Bin, clear the bit counter, and go to RUN.
REQ-014 SHALL, in RUN with enable=1, process one bit per clock, LSB first: d=a^b^br; br_next=(~a&b)|(~(a^b)&br).
REQ-015 SHALL, in RUN with enable=0, hold the state, counter, shift registers and borrow unchanged.
REQ-016 SHALL, on the enabled RUN edge that processes bit WIDTH-1, load Q={final borrow, D} and go to DONE.
REQ-017 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE on the next edge regardless of enable.
REQ-018 SHALL set latency so that done is high WIDTH enabled RUN cycles after the acceptance edge (4 cycles with no stalls); stall cycles add latency 1:1.
REQ-019 SHALL drive busy=1 in RUN and DONE and busy=0 in IDLE.
REQ-020 SHALL ignore start in RUN and DONE; inputs A, B and Bin may change freely after acceptance without affecting the result.
REQ-021 SHALL hold Q at its last result until the next completion; Q never shows partial results.
REQ-022 SHALL handle wrap-around: a negative true result yields its two's-complement low WIDTH bits in D with Bout=1.

Reset
REQ-023 SHALL, on rising clk with rst_n=0, force IDLE, Q=0, busy=0, done=0, counter=0 and borrow=0; rst_n has priority over all other inputs.
REQ-024 SHALL abort any in-flight operation on reset mid-RUN, with no done pulse and Q=0.
REQ-025 SHALL allow a new request to be accepted on the first edge after rst_n returns high.

Structure
REQ-026 SHALL take the WIDTH default and the IDLE/RUN/DONE state encoding from a shared package, rbs_pkg.
REQ-027 SHALL instantiate one combinational sub-module, full_subtractor (a, b, bin -> d, bout), for the per-bit stage.
REQ-028 SHALL use a counter sized for ceil(log2(WIDTH)) bits and right-shift operand registers.

Verification
REQ-029 SHALL verify A=0001, B=0111, Bin=0 -> Q=5'b11010 with done exactly 4 cycles after acceptance.
REQ-030 SHALL verify A=1000, B=0111, Bin=1 -> Q=5'b00000; A=0000, B=1111, Bin=1 -> Q=5'b10000.
REQ-031 SHALL verify A=1100, B=0100, Bin=0 with enable low for 2 RUN cycles -> Q=5'b01000, done 6 cycles after acceptance.
REQ-032 SHALL verify start pulsed with new operands while busy=1 -> ignored, and the first result is unaffected.
REQ-033 SHALL verify rst_n low for one cycle mid-RUN -> IDLE, Q=0, no done pulse, and the next request computes correctly.
REQ-034 SHALL verify that back-to-back requests, with start held high, are accepted only in IDLE, one cycle after each done.

Source files
------------

// File: rtl/rbs_pkg.sv
// Shared definitions for the bit-serial ripple-borrow subtractor:
// default operand width and the controller state encoding.
package rbs_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow out of this bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/rbs_serial_4bits.sv
// Bit-serial subtractor: latches A, B, Bin on start and produces {Bout, A-B-Bin}
// one bit per enabled clock, LSB first, with a one-cycle done strobe.
module rbs_serial_4bits
    import rbs_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH:0]   Q,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             br_q, br_d;
    logic [WIDTH:0]   q_q, q_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fs_diff;
    logic             fs_borrow;
    logic [WIDTH-1:0] d_shifted;

    full_subtractor u_full_subtractor (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_diff),
        .bout (fs_borrow)
    );

    // Each new difference bit enters at the MSB so D is LSB-aligned after WIDTH shifts.
    assign d_shifted = WIDTH'({fs_diff, d_q} >> 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        br_d    = br_q;
        q_d     = q_q;

        unique case (state_q)
            StIdle: begin
                if (start && enable) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (enable) begin
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    d_d   = d_shifted;
                    br_d  = fs_borrow;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        q_d     = {fs_borrow, d_shifted};
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            br_q    <= br_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_rbs_serial_4bits.sv
// Self-checking bench for rbs_serial_4bits: directed vectors, stalls, resets and
// randomized operations against an arithmetic reference (A - B - Bin).
module tb_rbs_serial_4bits;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic [W:0]   Q;
    logic         busy;
    logic         done;

    int           checks;
    int           errors;
    logic [W:0]   last_q;

    rbs_serial_4bits #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .start  (start),
        .A      (A),
        .B      (B),
        .Bin    (Bin),
        .Q      (Q),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction; borrow out means the true result is negative.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        int diff;
        diff = int'(a) - int'(b) - int'(bin);
        return {(diff < 0) ? 1'b1 : 1'b0, W'(diff)};
    endfunction

    // mode 0: no stalls, 1: enable low for slen cycles from RUN cycle s0, 2: random enable.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input int mode, input int s0, input int slen,
                         input bit hold_start, input string tag);
        int         n_en;
        int         cyc;
        logic       en;
        logic [W:0] exp_q;
        exp_q  = ref_sub(a, b, bin);
        A      = a;
        B      = b;
        Bin    = bin;
        start  = 1'b1;
        enable = 1'b1;
        tick();
        check({tag, "_accept_busy"}, 32'(busy), 32'(1));
        check({tag, "_accept_done"}, 32'(done), 32'(0));
        n_en = 0;
        cyc  = 0;
        while (n_en < W && cyc < 64) begin
            if (mode == 0)      en = 1'b1;
            else if (mode == 1) en = !(cyc >= s0 && cyc < s0 + slen);
            else                en = ($urandom_range(0, 3) != 0);
            enable = en;
            start  = hold_start ? 1'b1 : 1'($urandom);
            A      = W'($urandom);
            B      = W'($urandom);
            Bin    = 1'($urandom);
            tick();
            cyc++;
            if (en) n_en++;
            if (n_en < W) begin
                check({tag, "_run_busy"}, 32'(busy), 32'(1));
                check({tag, "_run_done"}, 32'(done), 32'(0));
                check({tag, "_run_q_hold"}, 32'(Q), 32'(last_q));
            end
        end
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_q"}, 32'(Q), 32'(exp_q));
        check({tag, "_done_busy"}, 32'(busy), 32'(1));
        if (mode != 2) check({tag, "_latency"}, 32'(cyc), 32'(W + ((mode == 1) ? slen : 0)));
        last_q = exp_q;
        enable = 1'($urandom);
        start  = hold_start ? 1'b1 : 1'($urandom);
        tick();
        check({tag, "_idle_done"}, 32'(done), 32'(0));
        check({tag, "_idle_busy"}, 32'(busy), 32'(0));
        check({tag, "_idle_q"}, 32'(Q), 32'(exp_q));
        start  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_q = '0;
        rst_n  = 1'b0;
        enable = 1'b1;
        start  = 1'b1;
        A      = 4'b0101;
        B      = 4'b0011;
        Bin    = 1'b0;

        // Reset wins over a simultaneous start.
        tick();
        tick();
        check("reset_q", 32'(Q), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check("post_reset_idle", 32'(busy), 32'(0));

        do_op(4'b0001, 4'b0111, 1'b0, 0, 0, 0, 1'b0, "v1");
        do_op(4'b1000, 4'b0111, 1'b1, 0, 0, 0, 1'b0, "v2");
        do_op(4'b0000, 4'b1111, 1'b1, 0, 0, 0, 1'b0, "v3");
        do_op(4'b1100, 4'b0100, 1'b0, 1, 1, 2, 1'b0, "stall");
        check("v1_const", 32'(ref_sub(4'b0001, 4'b0111, 1'b0)), 32'(5'b11010));

        // start held high: busy-time requests ignored, re-accepted one cycle after done.
        do_op(4'b0110, 4'b1001, 1'b0, 0, 0, 0, 1'b1, "b2b0");
        start = 1'b1;
        do_op(4'b1111, 4'b0001, 1'b1, 0, 0, 0, 1'b1, "b2b1");
        do_op(4'b0011, 4'b0011, 1'b1, 0, 0, 0, 1'b0, "b2b2");

        // Reset mid-RUN aborts without a done pulse.
        A      = 4'b1010;
        B      = 4'b0001;
        Bin    = 1'b0;
        start  = 1'b1;
        enable = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_q", 32'(Q), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        rst_n  = 1'b1;
        last_q = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_nodone", 32'(done), 32'(0));
            check("midrst_q_zero", 32'(Q), 32'(0));
        end

        // Second abort, then a request on the very first edge after release.
        start = 1'b1;
        A     = 4'b0111;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst2_q", 32'(Q), 32'(0));
        rst_n = 1'b1;
        do_op(4'b0010, 4'b0101, 1'b1, 0, 0, 0, 1'b0, "after_rst");

        for (int i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 2, 0, 0, 1'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
